omsp_spm_control: RTL and testbench

//  Sequencer for the bank of SPM protection slots. Serves protect/unprotect requests from the execution unit.

---
 rtl/omsp_spm_control_pkg.sv | 33 +++
 rtl/omsp_spm_range_ovl.sv | 17 +
 rtl/omsp_spm_control.sv | 188 ++++++++++++++++++
 tb/tb_omsp_spm_control.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/omsp_spm_control_pkg.sv
// Shared definitions for the SPM protection-slot sequencer: FSM state
// encoding, result codes, operation encoding and a small address helper.
package omsp_spm_control_pkg;

    // Sequencer states, in the order a protect request walks through them.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } spm_state_e;

    // Result codes reported alongside the done pulse.
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LAYOUT  = 2'd1,
        ERR_OVERLAP = 2'd2,
        ERR_NOSLOT  = 2'd3
    } spm_err_e;

    // Operation requested by the execution unit (req_protect value).
    localparam logic OP_UNPROTECT = 1'b0;
    localparam logic OP_PROTECT   = 1'b1;

    // True when addr lies in the half-open window [s, e).
    function automatic logic in_range(input logic [15:0] addr,
                                      input logic [15:0] s,
                                      input logic [15:0] e);
        return (s <= addr) && (addr < e);
    endfunction

endpackage

// File: rtl/omsp_spm_range_ovl.sv
// Combinational overlap test between two half-open address ranges
// [a,b) and [c,d). An empty range (start==end) never overlaps anything,
// so both ranges must be non-empty before the crossing test counts.
module omsp_spm_range_ovl (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    output logic        hit
);

    // Unsigned compare; the non-empty terms keep start==end ranges inert.
    always_comb begin
        hit = (a < b) && (c < d) && (a < d) && (c < b);
    end

endmodule

// File: rtl/omsp_spm_control.sv
// Sequencer for the bank of SPM protection slots. A protect request
// validates the new layout, scans every slot for overlap and a free slot,
// then programs one slot. An unprotect request finds the slot whose public
// section contains pc and clears it. Slot readback is combinational on
// scan_idx; the layout to be written travels to the slots on r12..r15.
module omsp_spm_control
    import omsp_spm_control_pkg::*;
#(
    parameter int NB_SPMS   = 4,
    parameter int SPM_IDX_W = 2
) (
    input  logic                 mclk,
    input  logic                 puc_rst_n,
    input  logic [15:0]          pc,
    input  logic                 req_start,
    input  logic                 req_protect,
    input  logic [15:0]          r12,
    input  logic [15:0]          r13,
    input  logic [15:0]          r14,
    input  logic [15:0]          r15,
    output logic [SPM_IDX_W-1:0] scan_idx,
    input  logic                 rd_enabled,
    input  logic [15:0]          rd_pub_start,
    input  logic [15:0]          rd_pub_end,
    input  logic [15:0]          rd_priv_start,
    input  logic [15:0]          rd_priv_end,
    output logic [NB_SPMS-1:0]   slot_update,
    output logic                 slot_enable,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic [3:0]           spm_id,
    output logic [2:0]           dbg_state
);

    localparam logic [SPM_IDX_W-1:0] LAST_IDX = SPM_IDX_W'(NB_SPMS - 1);

    spm_state_e           state, state_d;
    spm_err_e             err_q, err_d;
    logic                 op_q;
    logic [15:0]          pc_q;
    logic [15:0]          pub_s, pub_e, priv_s, priv_e;
    logic [SPM_IDX_W-1:0] scan_cnt, scan_d;
    logic [SPM_IDX_W-1:0] target_q, target_d;
    logic                 ovl_q, ovl_d;
    logic                 found_q, found_d;
    logic                 load;

    logic                 self_check;
    logic [15:0]          pp_c, pp_d;
    logic                 hit_pp, hit_pv, hit_vp, hit_vv;
    logic                 slot_hit, pc_hit, layout_bad;

    // In CHECK the first comparator is borrowed to test the new public
    // section against the new private section; during SCAN it compares
    // the new public section against the slot's public section.
    assign self_check = (state == ST_CHECK);
    assign pp_c       = self_check ? priv_s : rd_pub_start;
    assign pp_d       = self_check ? priv_e : rd_pub_end;

    omsp_spm_range_ovl u_ovl_pp (.a(pub_s),  .b(pub_e),  .c(pp_c),          .d(pp_d),        .hit(hit_pp));
    omsp_spm_range_ovl u_ovl_pv (.a(pub_s),  .b(pub_e),  .c(rd_priv_start), .d(rd_priv_end), .hit(hit_pv));
    omsp_spm_range_ovl u_ovl_vp (.a(priv_s), .b(priv_e), .c(rd_pub_start),  .d(rd_pub_end),  .hit(hit_vp));
    omsp_spm_range_ovl u_ovl_vv (.a(priv_s), .b(priv_e), .c(rd_priv_start), .d(rd_priv_end), .hit(hit_vv));

    assign slot_hit   = rd_enabled && (hit_pp || hit_pv || hit_vp || hit_vv);
    assign pc_hit     = rd_enabled && in_range(pc_q, rd_pub_start, rd_pub_end);
    assign layout_bad = (pub_s >= pub_e) || (priv_s >= priv_e) || hit_pp;

    // Next-state and scan bookkeeping; the flags accumulate across SCAN
    // and the decision on the last slot includes that slot's own result.
    always_comb begin
        state_d  = state;
        err_d    = err_q;
        ovl_d    = ovl_q;
        found_d  = found_q;
        target_d = target_q;
        scan_d   = scan_cnt;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                scan_d   = '0;
                ovl_d    = 1'b0;
                found_d  = 1'b0;
                target_d = '0;
                err_d    = ERR_NONE;
                if (req_start) begin
                    load    = 1'b1;
                    state_d = req_protect ? ST_CHECK : ST_SCAN;
                end
            end
            ST_CHECK: begin
                if (layout_bad) begin
                    err_d   = ERR_LAYOUT;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (op_q == OP_PROTECT) begin
                    if (slot_hit) begin
                        ovl_d = 1'b1;
                    end
                    if (!rd_enabled && !found_q) begin
                        found_d  = 1'b1;
                        target_d = scan_cnt;
                    end
                end else if (pc_hit && !found_q) begin
                    found_d  = 1'b1;
                    target_d = scan_cnt;
                end
                if (scan_cnt == LAST_IDX) begin
                    scan_d = '0;
                    if (ovl_d) begin
                        err_d   = ERR_OVERLAP;
                        state_d = ST_DONE;
                    end else if (!found_d) begin
                        err_d   = ERR_NOSLOT;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end else begin
                    scan_d = scan_cnt + 1'b1;
                end
            end
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State, latched request and scan/result registers.
    always_ff @(posedge mclk) begin
        if (!puc_rst_n) begin
            state    <= ST_IDLE;
            err_q    <= ERR_NONE;
            op_q     <= OP_UNPROTECT;
            pc_q     <= '0;
            pub_s    <= '0;
            pub_e    <= '0;
            priv_s   <= '0;
            priv_e   <= '0;
            scan_cnt <= '0;
            target_q <= '0;
            ovl_q    <= 1'b0;
            found_q  <= 1'b0;
        end else begin
            state    <= state_d;
            err_q    <= err_d;
            scan_cnt <= scan_d;
            target_q <= target_d;
            ovl_q    <= ovl_d;
            found_q  <= found_d;
            if (load) begin
                op_q   <= req_protect;
                pc_q   <= pc;
                pub_s  <= r12;
                pub_e  <= r13;
                priv_s <= r14;
                priv_e <= r15;
            end
        end
    end

    // Outputs decoded from state; strobes are suppressed while reset is
    // held so an aborted request never commits or completes.
    always_comb begin
        slot_update = '0;
        if ((state == ST_COMMIT) && puc_rst_n) begin
            for (int i = 0; i < NB_SPMS; i++) begin
                if (target_q == SPM_IDX_W'(i)) begin
                    slot_update[i] = 1'b1;
                end
            end
        end
    end

    assign slot_enable = (state == ST_COMMIT) ? op_q : 1'b0;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE) && puc_rst_n;
    assign err         = done ? err_q : ERR_NONE;
    assign spm_id      = (done && (err_q == ERR_NONE)) ? (4'(target_q) + 4'd1) : 4'd0;
    assign scan_idx    = (state == ST_SCAN) ? scan_cnt : '0;
    assign dbg_state   = state;

endmodule

// File: tb/tb_omsp_spm_control.sv
// Directed bench for omsp_spm_control with a four-slot readback model.
// Cycle 0 is the cycle in which req_start is high.
module tb_omsp_spm_control;

    logic        mclk;
    logic        puc_rst_n;
    logic [15:0] pc;
    logic        req_start;
    logic        req_protect;
    logic [15:0] r12, r13, r14, r15;
    logic [1:0]  scan_idx;
    logic        rd_enabled;
    logic [15:0] rd_pub_start, rd_pub_end, rd_priv_start, rd_priv_end;
    logic [3:0]  slot_update;
    logic        slot_enable;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [3:0]  spm_id;
    logic [2:0]  dbg_state;

    // slot model
    logic        m_en  [4];
    logic [15:0] m_ps  [4];
    logic [15:0] m_pe  [4];
    logic [15:0] m_vs  [4];
    logic [15:0] m_ve  [4];

    assign rd_enabled    = m_en[scan_idx];
    assign rd_pub_start  = m_ps[scan_idx];
    assign rd_pub_end    = m_pe[scan_idx];
    assign rd_priv_start = m_vs[scan_idx];
    assign rd_priv_end   = m_ve[scan_idx];

    int pass_cnt = 0;
    int total_cnt = 0;

    // observations of the last request
    int         o_upd_cyc;
    logic [3:0] o_upd_val;
    logic       o_upd_en;
    int         o_done_cyc;
    int         o_done_cnt;
    logic [1:0] o_err;
    logic [3:0] o_id;
    logic       o_scan_moved;

    omsp_spm_control #(.NB_SPMS(4), .SPM_IDX_W(2)) dut (
        .mclk(mclk), .puc_rst_n(puc_rst_n), .pc(pc),
        .req_start(req_start), .req_protect(req_protect),
        .r12(r12), .r13(r13), .r14(r14), .r15(r15),
        .scan_idx(scan_idx), .rd_enabled(rd_enabled),
        .rd_pub_start(rd_pub_start), .rd_pub_end(rd_pub_end),
        .rd_priv_start(rd_priv_start), .rd_priv_end(rd_priv_end),
        .slot_update(slot_update), .slot_enable(slot_enable),
        .busy(busy), .done(done), .err(err), .spm_id(spm_id),
        .dbg_state(dbg_state)
    );

    // clock
    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic clear_slots();
        for (int i = 0; i < 4; i++) begin
            m_en[i] = 1'b0; m_ps[i] = '0; m_pe[i] = '0; m_vs[i] = '0; m_ve[i] = '0;
        end
    endtask

    task automatic set_slot(input int i, input logic [15:0] ps, pe, vs, ve);
        m_en[i] = 1'b1; m_ps[i] = ps; m_pe[i] = pe; m_vs[i] = vs; m_ve[i] = ve;
    endtask

    // Observe one cycle: apply any slot write to the model, record done.
    task automatic observe(input int c);
        if (slot_update != 4'd0) begin
            o_upd_cyc = c; o_upd_val = slot_update; o_upd_en = slot_enable;
            for (int i = 0; i < 4; i++) begin
                if (slot_update[i]) begin
                    m_en[i] = slot_enable;
                    if (slot_enable) begin
                        m_ps[i] = r12; m_pe[i] = r13; m_vs[i] = r14; m_ve[i] = r15;
                    end
                end
            end
        end
        if (scan_idx != 2'd0) o_scan_moved = 1'b1;
        if (done) begin
            o_done_cnt++;
            if (o_done_cyc < 0) begin
                o_done_cyc = c; o_err = err; o_id = spm_id;
            end
        end
    endtask

    // Issue one request in cycle 0 and watch 16 cycles.
    task automatic do_req(input logic prot, input logic [15:0] p,
                          input logic [15:0] a, b, c, d);
        o_upd_cyc = -1; o_upd_val = '0; o_upd_en = 1'b0;
        o_done_cyc = -1; o_done_cnt = 0; o_err = '0; o_id = '0; o_scan_moved = 1'b0;
        req_start = 1'b1; req_protect = prot; pc = p;
        r12 = a; r13 = b; r14 = c; r15 = d;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge mclk); #1;
            if (cyc == 1) req_start = 1'b0;
            observe(cyc);
        end
    endtask

    task automatic test_reset();
        puc_rst_n = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0h expected 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0h expected 0", done); else pass_cnt++;
        total_cnt++; if (slot_update !== 4'd0) $display("FAIL reset_update: got %0h expected 0", slot_update); else pass_cnt++;
        total_cnt++; if (scan_idx !== 2'd0) $display("FAIL reset_scan_idx: got %0h expected 0", scan_idx); else pass_cnt++;
        total_cnt++; if (err !== 2'd0) $display("FAIL reset_err: got %0h expected 0", err); else pass_cnt++;
        total_cnt++; if (spm_id !== 4'd0) $display("FAIL reset_spm_id: got %0h expected 0", spm_id); else pass_cnt++;
        total_cnt++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0h expected 0", dbg_state); else pass_cnt++;
        puc_rst_n = 1'b1;
        @(posedge mclk); #1;
    endtask

    task automatic test_protect_first();
        clear_slots();
        do_req(1'b1, 16'h0000, 16'hA000, 16'hA100, 16'h0200, 16'h0280);
        total_cnt++; if (o_upd_cyc !== 6) $display("FAIL prot1_upd_cycle: got %0d expected 6", o_upd_cyc); else pass_cnt++;
        total_cnt++; if (o_upd_val !== 4'b0001) $display("FAIL prot1_upd_val: got %0h expected 1", o_upd_val); else pass_cnt++;
        total_cnt++; if (o_upd_en !== 1'b1) $display("FAIL prot1_enable: got %0h expected 1", o_upd_en); else pass_cnt++;
        total_cnt++; if (o_done_cyc !== 7) $display("FAIL prot1_done_cycle: got %0d expected 7", o_done_cyc); else pass_cnt++;
        total_cnt++; if (o_err !== 2'd0) $display("FAIL prot1_err: got %0h expected 0", o_err); else pass_cnt++;
        total_cnt++; if (o_id !== 4'd1) $display("FAIL prot1_id: got %0h expected 1", o_id); else pass_cnt++;
    endtask

    task automatic test_overlap();
        // slot0 now holds A000-A100 from the previous test
        do_req(1'b1, 16'h0000, 16'hA0F0, 16'hA200, 16'h0300, 16'h0380);
        total_cnt++; if (o_err !== 2'd2) $display("FAIL ovl_err: got %0h expected 2", o_err); else pass_cnt++;
        total_cnt++; if (o_done_cyc !== 6) $display("FAIL ovl_done_cycle: got %0d expected 6", o_done_cyc); else pass_cnt++;
        total_cnt++; if (o_upd_cyc !== -1) $display("FAIL ovl_no_update: got %0d expected -1", o_upd_cyc); else pass_cnt++;
        total_cnt++; if (o_id !== 4'd0) $display("FAIL ovl_id: got %0h expected 0", o_id); else pass_cnt++;
    endtask

    task automatic test_protect_second();
        do_req(1'b1, 16'h0000, 16'hB000, 16'hB100, 16'h0400, 16'h0480);
        total_cnt++; if (o_upd_val !== 4'b0010) $display("FAIL prot2_upd_val: got %0h expected 2", o_upd_val); else pass_cnt++;
        total_cnt++; if (o_id !== 4'd2) $display("FAIL prot2_id: got %0h expected 2", o_id); else pass_cnt++;
        total_cnt++; if (o_done_cnt !== 1) $display("FAIL prot2_done_count: got %0d expected 1", o_done_cnt); else pass_cnt++;
    endtask

    task automatic test_layout();
        do_req(1'b1, 16'h0000, 16'hA100, 16'hA000, 16'h0200, 16'h0280);
        total_cnt++; if (o_err !== 2'd1) $display("FAIL layout_err: got %0h expected 1", o_err); else pass_cnt++;
        total_cnt++; if (o_done_cyc !== 2) $display("FAIL layout_done_cycle: got %0d expected 2", o_done_cyc); else pass_cnt++;
        total_cnt++; if (o_scan_moved !== 1'b0) $display("FAIL layout_scan_idx: got %0h expected 0", o_scan_moved); else pass_cnt++;
        // public and private sections overlapping each other
        do_req(1'b1, 16'h0000, 16'hC000, 16'hC100, 16'hC080, 16'hC200);
        total_cnt++; if (o_err !== 2'd1) $display("FAIL self_ovl_err: got %0h expected 1", o_err); else pass_cnt++;
    endtask

    task automatic test_no_slot();
        clear_slots();
        set_slot(0, 16'h1000, 16'h1100, 16'h5000, 16'h5100);
        set_slot(1, 16'h2000, 16'h2100, 16'h6000, 16'h6100);
        set_slot(2, 16'h3000, 16'h3100, 16'h7000, 16'h7100);
        set_slot(3, 16'h4000, 16'h4100, 16'h8000, 16'h8100);
        // private end touches slot3 public start exactly: [0x3F00,0x4000) vs [0x4000,...) is disjoint
        do_req(1'b1, 16'h0000, 16'hC000, 16'hC100, 16'h3F00, 16'h4000);
        total_cnt++; if (o_err !== 2'd3) $display("FAIL noslot_err: got %0h expected 3", o_err); else pass_cnt++;
        total_cnt++; if (o_id !== 4'd0) $display("FAIL noslot_id: got %0h expected 0", o_id); else pass_cnt++;
        total_cnt++; if (o_done_cyc !== 6) $display("FAIL noslot_done_cycle: got %0d expected 6", o_done_cyc); else pass_cnt++;
    endtask

    task automatic test_unprotect();
        clear_slots();
        set_slot(2, 16'hB000, 16'hB100, 16'h0800, 16'h0880);
        do_req(1'b0, 16'hB100, 16'h0, 16'h0, 16'h0, 16'h0);
        total_cnt++; if (o_err !== 2'd3) $display("FAIL unprot_edge_err: got %0h expected 3", o_err); else pass_cnt++;
        total_cnt++; if (o_done_cyc !== 5) $display("FAIL unprot_edge_done_cycle: got %0d expected 5", o_done_cyc); else pass_cnt++;
        total_cnt++; if (o_upd_cyc !== -1) $display("FAIL unprot_edge_no_update: got %0d expected -1", o_upd_cyc); else pass_cnt++;
        do_req(1'b0, 16'hB010, 16'h0, 16'h0, 16'h0, 16'h0);
        total_cnt++; if (o_upd_val !== 4'b0100) $display("FAIL unprot_upd_val: got %0h expected 4", o_upd_val); else pass_cnt++;
        total_cnt++; if (o_upd_en !== 1'b0) $display("FAIL unprot_enable: got %0h expected 0", o_upd_en); else pass_cnt++;
        total_cnt++; if (o_id !== 4'd3) $display("FAIL unprot_id: got %0h expected 3", o_id); else pass_cnt++;
        total_cnt++; if (o_done_cyc !== 6) $display("FAIL unprot_done_cycle: got %0d expected 6", o_done_cyc); else pass_cnt++;
        total_cnt++; if (m_en[2] !== 1'b0) $display("FAIL unprot_slot_cleared: got %0h expected 0", m_en[2]); else pass_cnt++;
    endtask

    task automatic test_reset_mid_scan();
        logic busy_after;
        clear_slots();
        o_upd_cyc = -1; o_done_cyc = -1; o_done_cnt = 0; o_scan_moved = 1'b0;
        busy_after = 1'b1;
        req_start = 1'b1; req_protect = 1'b1; pc = 16'h0;
        r12 = 16'hA000; r13 = 16'hA100; r14 = 16'h0200; r15 = 16'h0280;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge mclk); #1;
            if (cyc == 1) req_start = 1'b0;
            if (cyc == 4) busy_after = busy;
            puc_rst_n = (cyc == 3) ? 1'b0 : 1'b1;
            observe(cyc);
        end
        total_cnt++; if (busy_after !== 1'b0) $display("FAIL rst_scan_busy: got %0h expected 0", busy_after); else pass_cnt++;
        total_cnt++; if (o_upd_cyc !== -1) $display("FAIL rst_scan_no_update: got %0d expected -1", o_upd_cyc); else pass_cnt++;
        total_cnt++; if (o_done_cnt !== 0) $display("FAIL rst_scan_no_done: got %0d expected 0", o_done_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_slots();
        o_upd_cyc = -1; o_done_cyc = -1; o_done_cnt = 0; o_scan_moved = 1'b0;
        req_start = 1'b1; req_protect = 1'b0; pc = 16'h1234;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(posedge mclk); #1;
            // a second request arrives while busy and must be dropped
            req_start = (cyc == 2) ? 1'b1 : 1'b0;
            req_protect = (cyc == 2) ? 1'b1 : 1'b0;
            observe(cyc);
        end
        total_cnt++; if (o_done_cnt !== 1) $display("FAIL b2b_done_count: got %0d expected 1", o_done_cnt); else pass_cnt++;
        total_cnt++; if (o_err !== 2'd3) $display("FAIL b2b_err: got %0h expected 3", o_err); else pass_cnt++;
        total_cnt++; if (o_upd_cyc !== -1) $display("FAIL b2b_no_update: got %0d expected -1", o_upd_cyc); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %0h expected 0", busy); else pass_cnt++;
    endtask

    initial begin
        puc_rst_n = 1'b0; req_start = 1'b0; req_protect = 1'b0; pc = '0;
        r12 = '0; r13 = '0; r14 = '0; r15 = '0;
        clear_slots();
        @(negedge mclk);
        test_reset();
        test_protect_first();
        test_overlap();
        test_protect_second();
        test_layout();
        test_no_slot();
        test_unprotect();
        test_reset_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
